// File: rtl/alu_sequencer_if.sv
// Bus bundle between the sequencer, instruction memory, register file and ALU.
interface alu_sequencer_if;
  // instruction memory
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  // register file
  logic [2:0]  rf_raddr1;
  logic [2:0]  rf_raddr2;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  // ALU
  logic [15:0] op1_regaddr;
  logic [15:0] op2_regaddr;
  logic [3:0]  alu_opcode;
  logic [1:0]  alu_ot;
  logic [15:0] alu_out;
  logic [15:0] alu_addr_out;
  logic        alu_za;
  logic        alu_zb;
  logic        alu_eq;
  logic        alu_gt;
  logic        alu_lt;

  modport master (
    output imem_req, imem_addr, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
           op1_regaddr, op2_regaddr, alu_opcode, alu_ot,
    input  imem_ack, imem_rdata, alu_out, alu_addr_out,
           alu_za, alu_zb, alu_eq, alu_gt, alu_lt
  );

  modport slave (
    input  imem_req, imem_addr, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
           op1_regaddr, op2_regaddr, alu_opcode, alu_ot,
    output imem_ack, imem_rdata, alu_out, alu_addr_out,
           alu_za, alu_zb, alu_eq, alu_gt, alu_lt
  );
endinterface

// File: rtl/alu_sequencer.sv
// Multi-cycle control unit for the 16-bit CPU: fetch, decode, execute on the
// combinational ALU, write back to the register file, relative jumps.
module alu_sequencer #(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  alu_sequencer_if.master bus,
  output logic [4:0]      flags,
  output logic            busy,
  output logic            halted,
  output logic            fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK,
    S_HALT
  } state_t;

  localparam logic [7:0] WAIT_LIMIT = 8'(FETCH_TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] pc;
  logic [15:0] ir;
  logic [15:0] result;
  logic [2:0]  dest;
  logic [4:0]  flags_q;
  logic [7:0]  wait_cnt;
  logic        fault_q;
  logic        jump_taken;
  logic        unused_addr_bits;

  logic [1:0]  cls;
  logic [3:0]  sub;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic [15:0] offs_sext;

  assign cls       = ir[15:14];
  assign sub       = ir[13:10];
  assign rd        = ir[9:7];
  assign rs        = ir[6:4];
  assign offs_sext = {{6{ir[9]}}, ir[9:0]};

  // Only the low three bits address the 8-entry register file.
  assign unused_addr_bits = ^bus.alu_addr_out[15:3];

  // Conditional jumps test the flags latched by an earlier logic-class op.
  always_comb begin
    jump_taken = 1'b0;
    case (sub)
      4'b0001: jump_taken = 1'b1;
      4'b0010: jump_taken = flags_q[2];
      4'b0011: jump_taken = flags_q[1];
      4'b0100: jump_taken = flags_q[0];
      4'b0101: jump_taken = flags_q[4];
      default: jump_taken = 1'b0;
    endcase
  end

  // State register; reset aborts any instruction immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state and control outputs.
  always_comb begin
    state_nxt       = state;
    bus.imem_req    = 1'b0;
    bus.rf_raddr1   = '0;
    bus.rf_raddr2   = '0;
    bus.op1_regaddr = '0;
    bus.op2_regaddr = '0;
    bus.alu_opcode  = '0;
    bus.alu_ot      = '0;
    bus.rf_we       = 1'b0;
    bus.rf_waddr    = '0;
    bus.rf_wdata    = '0;
    busy            = 1'b0;
    halted          = 1'b0;
    if (state == S_DECODE || state == S_EXECUTE || state == S_WRITEBACK) begin
      bus.rf_raddr1   = rd;
      bus.rf_raddr2   = rs;
      bus.op1_regaddr = {13'b0, rd};
      bus.op2_regaddr = {13'b0, rs};
    end
    case (state)
      S_IDLE: if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        busy         = 1'b1;
        bus.imem_req = 1'b1;
        if (bus.imem_ack)              state_nxt = S_DECODE;
        else if (wait_cnt == WAIT_LIMIT) state_nxt = S_HALT;
      end
      S_DECODE: begin
        busy      = 1'b1;
        state_nxt = S_EXECUTE;
      end
      S_EXECUTE: begin
        busy           = 1'b1;
        bus.alu_opcode = sub;
        bus.alu_ot     = cls;
        if (cls == 2'b11)                        state_nxt = (sub == 4'b1111) ? S_HALT : S_FETCH;
        else if (cls == 2'b10 && sub == 4'b1111) state_nxt = S_FETCH;
        else                                     state_nxt = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        busy         = 1'b1;
        bus.rf_we    = 1'b1;
        bus.rf_waddr = dest;
        bus.rf_wdata = result;
        state_nxt    = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        if (start) state_nxt = S_FETCH;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: pc, instruction, result/destination, flags, fetch timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      ir       <= '0;
      result   <= '0;
      dest     <= '0;
      flags_q  <= '0;
      wait_cnt <= '0;
      fault_q  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (bus.imem_ack) begin
            ir       <= bus.imem_rdata;
            pc       <= pc + 16'd1;
            wait_cnt <= '0;
          end else if (wait_cnt == WAIT_LIMIT) begin
            fault_q  <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_EXECUTE: begin
          if (cls != 2'b11) begin
            result <= bus.alu_out;
            dest   <= bus.alu_addr_out[2:0];
            if (cls == 2'b10)
              flags_q <= {bus.alu_za, bus.alu_zb, bus.alu_eq, bus.alu_gt, bus.alu_lt};
          end else if (jump_taken) begin
            pc <= pc + offs_sext;
          end
        end
        S_HALT: begin
          if (start) begin
            pc      <= RESET_PC;
            fault_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.imem_addr = pc;
  assign flags         = flags_q;
  assign fault         = fault_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Randomized self-checking bench for alu_sequencer with an ISA-level model.
module tb_alu_sequencer;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] flags;
  logic       busy;
  logic       halted;
  logic       fault;

  alu_sequencer_if bus();

  alu_sequencer #(.RESET_PC(RST_PC), .FETCH_TIMEOUT(255)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .flags(flags), .busy(busy), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [15:0] m_pc;
  logic [4:0]  m_flags;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Runs one instruction from the first FETCH cycle to the next FETCH (or restart after HALT).
  task automatic exec_instr(input logic [15:0] instr, input int waits,
                            input logic [15:0] aout, input logic [15:0] aaddr, input logic [4:0] af);
    logic [1:0]  cls;
    logic [3:0]  sub;
    logic [2:0]  rd, rs;
    logic [15:0] npc;
    logic [15:0] offs;
    logic        taken;
    cls  = instr[15:14];
    sub  = instr[13:10];
    rd   = instr[9:7];
    rs   = instr[6:4];
    offs = {{6{instr[9]}}, instr[9:0]};
    check("fetch_req", bus.imem_req, 1);
    check("fetch_addr", bus.imem_addr, m_pc);
    for (int i = 0; i < waits; i++) begin
      bus.imem_ack = 1'b0;
      start = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    check("fetch_hold", bus.imem_req, 1);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = instr;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 16'($urandom);
    npc = m_pc + 16'd1;
    check("dec_busy", busy, 1);
    check("dec_raddr1", bus.rf_raddr1, rd);
    check("dec_raddr2", bus.rf_raddr2, rs);
    check("dec_op1", bus.op1_regaddr, 16'(rd));
    check("dec_op2", bus.op2_regaddr, 16'(rs));
    bus.alu_out      = aout;
    bus.alu_addr_out = aaddr;
    {bus.alu_za, bus.alu_zb, bus.alu_eq, bus.alu_gt, bus.alu_lt} = af;
    start = 1'($urandom_range(0, 1));
    @(negedge clk);
    check("ex_opcode", bus.alu_opcode, sub);
    check("ex_ot", bus.alu_ot, cls);
    check("ex_raddr1", bus.rf_raddr1, rd);
    check("ex_we", bus.rf_we, 0);
    @(negedge clk);
    if (cls != 2'b11) begin
      if (cls == 2'b10) m_flags = af;
      if (cls == 2'b10 && sub == 4'b1111) begin
        check("cmp_no_we", bus.rf_we, 0);
      end else begin
        check("wb_we", bus.rf_we, 1);
        check("wb_waddr", bus.rf_waddr, aaddr[2:0]);
        check("wb_wdata", bus.rf_wdata, aout);
        check("wb_raddr2", bus.rf_raddr2, rs);
        start = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("wb_once", bus.rf_we, 0);
      end
    end else begin
      check("ctl_no_we", bus.rf_we, 0);
      case (sub)
        4'd1:    taken = 1'b1;
        4'd2:    taken = m_flags[2];
        4'd3:    taken = m_flags[1];
        4'd4:    taken = m_flags[0];
        4'd5:    taken = m_flags[4];
        default: taken = 1'b0;
      endcase
      if (taken) npc = npc + offs;
      if (sub == 4'b1111) begin
        check("halt_halted", halted, 1);
        check("halt_req", bus.imem_req, 0);
        check("halt_busy", busy, 0);
        start = 1'b1;
        @(negedge clk);
        npc = RST_PC;
      end
    end
    start = 1'b0;
    m_pc  = npc;
    check("flags", flags, m_flags);
    check("no_fault", fault, 0);
  endtask

  task automatic reset_and_start();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_pc    = RST_PC;
    m_flags = '0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    logic [3:0]  subs [10];
    subs = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd15, 4'd7, 4'd9, 4'd1};
    w = 16'($urandom);
    if (w[15:14] == 2'b11) w[13:10] = subs[$urandom_range(0, 9)];
    else if (w[15:14] == 2'b10 && $urandom_range(0, 2) == 0) w[13:10] = 4'b1111;
    return w;
  endfunction

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    bus.alu_out = '0;
    bus.alu_addr_out = '0;
    {bus.alu_za, bus.alu_zb, bus.alu_eq, bus.alu_gt, bus.alu_lt} = '0;
    m_pc = RST_PC;
    m_flags = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_addr", bus.imem_addr, RST_PC);
    check("rst_req", bus.imem_req, 0);
    check("rst_busy", busy, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    check("rst_flags", flags, 0);
    check("rst_we", bus.rf_we, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req", bus.imem_req, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Arith op with fixed ALU response, then CMP/JEQ with eq set and clear.
    exec_instr(16'h4000 | (16'd2 << 7) | (16'd3 << 4), 0, 16'h1234, 16'h0002, 5'b0);
    exec_instr(16'hBC00, 0, 16'h0, 16'h0, 5'b00100);
    exec_instr(16'hCBFE, 0, 16'h0, 16'h0, 5'b0);
    exec_instr(16'hBC00, 1, 16'h0, 16'h0, 5'b00000);
    exec_instr(16'hCBFE, 2, 16'h0, 16'h0, 5'b0);

    // JMP -2 from pc 0 lands on FFFF; NOP there wraps to 0000.
    reset_and_start();
    exec_instr(16'hC7FE, 0, 16'h0, 16'h0, 5'b0);
    check("wrap_pc", m_pc, 16'hFFFF);
    exec_instr(16'hC000, 0, 16'h0, 16'h0, 5'b0);

    // Fetch timeout: 255 cycles without ack faults into HALT.
    for (int i = 0; i < 254; i++) @(negedge clk);
    check("to_still_req", bus.imem_req, 1);
    check("to_no_fault_yet", fault, 0);
    @(negedge clk);
    check("to_fault", fault, 1);
    check("to_halted", halted, 1);
    check("to_req", bus.imem_req, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    m_pc = RST_PC;
    check("restart_fault", fault, 0);
    // Ack on the 255th wait cycle still wins.
    exec_instr(16'hC000, 254, 16'h0, 16'h0, 5'b0);

    // HALT instruction.
    exec_instr(16'hFC00, 0, 16'h0, 16'h0, 5'b0);

    // Randomized program.
    for (int n = 0; n < 200; n++)
      exec_instr(rand_instr(), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0,
                 16'($urandom), 16'($urandom), 5'($urandom));

    // Reset during WRITEBACK drops the write immediately.
    check("rw_fetch", bus.imem_req, 1);
    bus.imem_ack = 1'b1;
    bus.imem_rdata = 16'h4000 | (16'd5 << 7);
    @(negedge clk);
    bus.imem_ack = 1'b0;
    bus.alu_out = 16'hBEEF;
    bus.alu_addr_out = 16'h0005;
    @(negedge clk);
    @(negedge clk);
    check("rw_we_before", bus.rf_we, 1);
    #2 rst = 1'b1;
    #1;
    check("rw_we", bus.rf_we, 0);
    check("rw_wdata", bus.rf_wdata, 0);
    check("rw_busy", busy, 0);
    check("rw_addr", bus.imem_addr, RST_PC);
    check("rw_flags", flags, 0);
    check("rw_req", bus.imem_req, 0);
    @(negedge clk);
    rst = 1'b0;
    m_pc = RST_PC;
    m_flags = '0;
    @(negedge clk);
    check("rw_idle", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 0; n < 20; n++)
      exec_instr(rand_instr(), 0, 16'($urandom), 16'($urandom), 5'($urandom));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle control unit for the 16-bit CPU.
- Fetches instructions over a req/ack instruction-memory handshake, decodes them and drives the ALU's opcode, output-type and register-address controls.
- Latches the ALU result and the compare flags (za/zb/eq/gt/lt), writes results back to the register file and executes conditional/relative jumps.
- Sits between instruction memory, the register file and the combinational ALU.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset and on restart from HALT.
- FETCH_TIMEOUT, 255, maximum wait cycles for imem_ack before a fetch fault (8-bit counter).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  leave IDLE/HALT and begin fetching.
- imem_req  out  1  fetch request, held until imem_ack.
- imem_addr  out  16  fetch address (= pc).
- imem_ack  in  1  instruction valid this cycle.
- imem_rdata  in  16  instruction word.
- rf_raddr1  out  3  source register for op1 (rd field).
- rf_raddr2  out  3  source register for op2 (rs field).
- op1_regaddr  out  16  zero-extended rd to ALU.
- op2_regaddr  out  16  zero-extended rs to ALU.
- alu_opcode  out  4  ALU opcode.
- alu_ot  out  2  ALU output type.
- alu_out  in  16  ALU result.
- alu_addr_out  in  16  ALU destination address.
- alu_za, alu_zb, alu_eq, alu_gt, alu_lt  in  1 each  ALU flags.
- rf_we  out  1  register write strobe (one cycle).
- rf_waddr  out  3  write address.
- rf_wdata  out  16  write data.
- flags  out  5  latched {za,zb,eq,gt,lt}.
- busy  out  1  high in FETCH/DECODE/EXECUTE/WRITEBACK.
- halted  out  1  high in HALT.
- fault  out  1  fetch timeout occurred; sticky until restart or reset.

Behaviour:
- Instruction format: [15:14] cls, [13:10] sub, [9:7] rd, [6:4] rs, [9:0] offs (control class only).
- cls encoding: 00 addressing, 01 arith, 10 logic, 11 control.
- Reset (async): state=IDLE, pc=RESET_PC, ir=0, flags=0, timeout count=0, fault=0. All outputs 0, except imem_addr=RESET_PC.
- IDLE: start=1 -> FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack: ir<=imem_rdata, pc<=pc+1 (wraps FFFF->0000), count<=0, -> DECODE.
  - Otherwise count++. When count reaches FETCH_TIMEOUT with no ack: fault<=1, -> HALT.
  - An ack arriving in the same cycle the count reaches the limit wins (no fault).
- DECODE:
  - rf_raddr1=rd, rf_raddr2=rs, op1/op2_regaddr driven from ir. These stay driven through WRITEBACK.
  - Next state: cls==11 -> EXECUTE (control); otherwise -> EXECUTE.
- EXECUTE:
  - alu_opcode=sub, alu_ot=cls.
  - cls 00/01/10: capture alu_out into the result register and alu_addr_out[2:0] into the destination register.
  - cls 10: flags<=ALU flags, captured only in this class.
  - cls 10 with sub=4'b1111 (CMP): flags only, no writeback -> FETCH.
  - Other cls 00/01/10 -> WRITEBACK.
  - cls 11 (alu_ot=11, ALU result ignored). Targets are relative to the already-incremented pc, mod 2^16:
    - sub 0000 NOP.
    - sub 0001 JMP: pc<=pc+sext(offs).
    - sub 0010 JEQ, 0011 JGT, 0100 JLT, 0101 JZA: jump if the latched flag (eq/gt/lt/za) is 1.
    - sub 1111 -> HALT.
    - All other subs behave as NOP.
    - Non-HALT -> FETCH.
- WRITEBACK: rf_we=1 for exactly this cycle with the captured rf_waddr/rf_wdata -> FETCH.
- Latency:
  - ALU op: 4 cycles with zero-wait ack (FETCH, DECODE, EXECUTE, WRITEBACK).
  - CMP/control: 3 cycles.
  - Each extra imem wait cycle adds 1.
- HALT: halted=1, imem_req=0. start=1 -> pc<=RESET_PC, fault<=0, flags kept, -> FETCH.
- start is ignored while busy.
- rst at any time aborts the instruction with no rf_we and returns to IDLE immediately, without waiting for a clock edge.

Test Plan:
- Reset then start with zero-wait memory, instr 16'h4000|rd=2|rs=3 (arith, sub 0), ALU returns alu_out=16'h1234, alu_addr_out=2 -> rf_we pulses once on the 4th cycle after start with rf_waddr=2, rf_wdata=16'h1234; imem_addr advances 0->1.
- CMP (cls 10, sub 1111) with alu_eq=1, then JEQ offs=10'h3FE (-2) at pc 1 -> no rf_we; next fetch address = 2-2 = 0. Repeat with eq=0 -> next fetch address = 2.
- Hold imem_ack low for 255 cycles -> fault=1, halted=1, imem_req=0. Then start=1 -> fault=0 and fetch from RESET_PC. Ack on exactly cycle 255 -> no fault.
- pc=16'hFFFF, NOP fetched -> next imem_addr=16'h0000.
- Assert rst during WRITEBACK -> rf_we=0 in that cycle, state IDLE, outputs at reset values, pc=RESET_PC.
- HALT instr (16'hFC00) -> halted=1 after 3 cycles. start pulsed while busy earlier has no effect.
